mem_responder: RTL
==================

Name: mem_responder

Overview:
- Backing-memory responder for the cache's external memory port; it is the far end of the mem_req/mem_resp protocol the cache drives.
- Accepts one 128-bit-beat request per cycle.
- Writes: takes a separate data beat with a byte mask and commits it to internal storage.
- Reads: returns one beat a fixed READ_LATENCY cycles after acceptance, in order, with no backpressure from the requester.
- Used as the simulation/FPGA main-memory model behind the cache.

Parameters:
MEM_DATA_BITS, 128, beat width in bits (matches `MEM_DATA_BITS)
MEM_ADDR_BITS, 28, beat address width (CPU word address minus log2(beat/word))
DEPTH_BITS, 10, storage holds 2^DEPTH_BITS beats; address bits above this are ignored (aliasing)
READ_LATENCY, 4, cycles from read acceptance to mem_resp_valid; legal range 1..8
MAX_OUTSTANDING, 4, maximum reads accepted but not yet responded

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
mem_req_valid  input  1  request present
mem_req_ready  output  1  request accepted this cycle if valid
mem_req_addr  input  MEM_ADDR_BITS  beat address
mem_req_rw  input  1  1 = write, 0 = read
mem_req_data_valid  input  1  write data beat present
mem_req_data_ready  output  1  write data beat accepted this cycle if valid
mem_req_data_bits  input  MEM_DATA_BITS  write data
mem_req_data_mask  input  MEM_DATA_BITS/8  byte enables; bit i covers bits [8i+7:8i]
mem_resp_valid  output  1  read response beat valid, one cycle per read
mem_resp_data  output  MEM_DATA_BITS  read response data

Behaviour:
- Reset (reset==0, async):
  - State -> IDLE; outstanding counter -> 0; delay-line valids cleared; pending write address cleared.
  - mem_resp_valid=0, mem_resp_data=0.
  - Storage contents are not cleared.
  - In-flight reads are dropped and produce no response after reset releases.
- States:
  - IDLE: no write pending.
  - WDATA: write request accepted, data beat not yet received.
- mem_req_ready = (state==IDLE) && (outstanding < MAX_OUTSTANDING).
  - Write requests are also refused when outstanding==MAX_OUTSTANDING, so the rule is uniform.
- mem_req_data_ready:
  - 1 in WDATA.
  - 1 in IDLE only when mem_req_valid && mem_req_rw && mem_req_ready (same-cycle data).
  - 0 otherwise.
  - A data beat without a matching write request is never consumed.
- Write, same cycle: IDLE, write request and data accepted together -> masked write committed at that edge; stay IDLE.
- Write, split: IDLE, write request accepted without data -> latch address; go to WDATA.
  - In WDATA, data accepted -> masked write to the latched address; go to IDLE.
  - WDATA holds indefinitely and accepts no requests.
- Masked write: byte i of the stored beat is replaced iff mask[i]. A mask of all zero accepts the beat but changes nothing.
- Read accept (IDLE, valid, rw=0, ready):
  - Storage is read at acceptance; the data is a snapshot.
  - A write accepted in a later cycle never alters an earlier read's response.
  - A write committed at an earlier edge is always visible.
- Read latency: accepted at edge N -> mem_resp_valid high for exactly the cycle after edge N+READ_LATENCY, with the captured data.
  - Back-to-back reads produce back-to-back responses, in order.
- mem_resp_data holds its last value when mem_resp_valid=0.
- Outstanding counter:
  - +1 on read accept; -1 on response cycle; unchanged when both happen.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- Address: only mem_req_addr[DEPTH_BITS-1:0] indexes storage; upper bits are ignored.
- Simultaneous events:
  - One request per cycle by construction.
  - A response emitting while a new read is accepted is legal.
  - A WDATA data beat arriving in the same cycle as a response is legal.

Decomposition:
- Shared constants include file: MEM_DATA_BITS, MEM_ADDR_BITS, and the IDLE/WDATA state encodings. These are reused with the cache's existing include.
- One sub-module, mem_resp_delay_line:
  - READ_LATENCY-stage shift register of {valid, data}.
  - Same async active-low reset.
  - Outputs feed mem_resp_valid/mem_resp_data directly.
- The top level holds storage, the FSM and the counter.

Test Plan:
- Write then read: write addr 0x5, data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, same-cycle data; read addr 0x5 next cycle -> mem_resp_valid exactly 4 cycles after read accept, data equal to the written beat.
- Byte mask: preload addr 0x9 with all-ones; write data 0, mask 0x000F -> later read returns 0xFFFF...FFFF_00000000 (low 4 bytes zero, rest 0xFF).
- Split write: write request to addr 0x3 with no data, then data arrives 3 cycles later.
  - mem_req_ready=0 during the wait; data_ready=1 only in WDATA.
  - A read of 0x3 after the beat returns the new data.
- Backpressure: issue 6 back-to-back reads (addrs 0..5).
  - Exactly 4 accepted; ready drops at count 4 and rises on the first response cycle.
  - All 6 responses arrive in order.
- Snapshot ordering: read addr 0x7 (old value A), then write B to 0x7 the next cycle -> response carries A; a subsequent read returns B.
- Reset mid-flight: accept 2 reads, assert reset=0 for 1 cycle before any response.
  - No mem_resp_valid ever appears for them; after release ready=1, count=0.
  - Storage retains data written before reset.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM encoding and byte-mask merge helper for the memory responder.
// Beat and address widths match the cache's external memory port.
package mem_responder_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

  typedef logic [MEM_DATA_BITS-1:0] beat_t;
  typedef logic [MEM_MASK_BITS-1:0] mask_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } resp_state_e;

  // Replace byte i of the old beat with byte i of the new beat when mask[i] is set.
  function automatic beat_t apply_mask(input beat_t old_beat, input beat_t new_beat,
                                       input mask_t mask);
    beat_t merged;
    merged = old_beat;
    for (int i = 0; i < MEM_MASK_BITS; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_beat[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/write-data/response bundle between the cache (master) and the memory model (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_req_rw;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  beat_t                    mem_req_data_bits;
  mask_t                    mem_req_data_mask;
  logic                     mem_resp_valid;
  beat_t                    mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_resp_delay_line.sv
// Fixed-latency shift register carrying read snapshots to the response port.
// Each stage only loads data alongside a valid, so the last stage holds its data between responses.
module mem_resp_delay_line
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  input  beat_t in_data,
  output logic  emit_next,
  output logic  out_valid,
  output beat_t out_data
);

  logic [LATENCY-1:0] valid_q;
  beat_t              data_q [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  // Flags that a response becomes visible after the coming edge.
  generate
    if (LATENCY == 1) begin : g_emit_single
      assign emit_next = in_valid;
    end else begin : g_emit_multi
      assign emit_next = valid_q[LATENCY-2];
    end
  endgenerate

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Main-memory model behind the cache: masked beat writes, fixed-latency in-order read responses.
// Holds the storage array, the write-split FSM and the outstanding-read counter.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_BITS      = 10,
  parameter int READ_LATENCY    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus
);

  localparam int                DEPTH    = 1 << DEPTH_BITS;
  localparam int                CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUTSTANDING);

  resp_state_e           state;
  resp_state_e           state_next;
  logic [DEPTH_BITS-1:0] wr_addr;
  logic [DEPTH_BITS-1:0] req_idx;
  logic [DEPTH_BITS-1:0] commit_idx;
  logic [CNT_BITS-1:0]   outstanding;
  logic [CNT_BITS-1:0]   outstanding_next;
  logic                  req_ready_q;
  logic                  accept_read;
  logic                  accept_write;
  logic                  data_fire;
  logic                  emit_next;
  logic                  rd_valid;
  beat_t                 rd_data;
  beat_t                 storage [DEPTH];
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same storage.
  assign req_idx        = bus.mem_req_addr[DEPTH_BITS-1:0];
  assign unused_addr_hi = ^bus.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

  assign bus.mem_req_ready      = req_ready_q;
  assign bus.mem_req_data_ready = (state == ST_WDATA) ||
                                  (bus.mem_req_valid && bus.mem_req_rw && req_ready_q);

  always_comb begin
    accept_read  = bus.mem_req_valid && !bus.mem_req_rw && req_ready_q;
    accept_write = bus.mem_req_valid &&  bus.mem_req_rw && req_ready_q;
    data_fire    = bus.mem_req_data_valid && bus.mem_req_data_ready;
    commit_idx   = (state == ST_WDATA) ? wr_addr : req_idx;

    state_next = state;
    case (state)
      ST_IDLE:  if (accept_write && !data_fire) state_next = ST_WDATA;
      ST_WDATA: if (data_fire) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // A response leaving and a read arriving in the same cycle cancel out.
    outstanding_next = outstanding;
    if (accept_read && !emit_next)      outstanding_next = outstanding + CNT_ONE;
    else if (!accept_read && emit_next) outstanding_next = outstanding - CNT_ONE;
  end

  // Ready is registered from the next-state view so it is glitch-free at the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      outstanding <= '0;
      req_ready_q <= 1'b1;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      req_ready_q <= (state_next == ST_IDLE) && (outstanding_next < CNT_MAX);
      if (state == ST_IDLE && accept_write && !data_fire) wr_addr <= req_idx;
    end
  end

  // Storage survives reset; reads snapshot the array at acceptance.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      storage[commit_idx] <= apply_mask(storage[commit_idx], bus.mem_req_data_bits,
                                        bus.mem_req_data_mask);
    end
    if (accept_read) rd_data <= storage[req_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= accept_read;
  end

  mem_resp_delay_line #(
    .LATENCY (READ_LATENCY)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_valid),
    .in_data   (rd_data),
    .emit_next (emit_next),
    .out_valid (bus.mem_resp_valid),
    .out_data  (bus.mem_resp_data)
  );

endmodule
